// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial add/subtract unit.
// State encoding and width limits.
package serial_arith_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell.
// The single arithmetic element of serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock.
// Result, carry-out and overflow presented with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  import serial_arith_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a  (opa_q[idx_q]),
    .b  (opb_q[idx_q]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction runs as a + ~b + 1.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = fa_s;
        carry_d      = fa_co;
        if (idx_q == LAST) begin
          // carry_q here is the carry into the MSB.
          cout_d  = fa_co;
          ovf_d   = fa_co ^ carry_q;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign ready    = ~busy;
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Outputs are sampled 1ns after the rising edge.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       ready, busy, done;
  logic [7:0] sum;
  logic       cout, overflow;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Launch one op; lat = rising edges from accept edge to done.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is,
                       output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = ~ic; sub = ~is;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op_check(input string tag,
                          input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic is,
                          input logic [7:0] es, input logic ec,
                          input logic eo);
    int lat;
    do_op(ia, ib, ic, is, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd8);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    chk({tag, "_rdy"}, 64'(ready), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(sum), 64'(es));
  endtask

  initial begin
    int lat;
    int n;
    int dones;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'h00);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    op_check("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op_check("add_0f_f0", 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op_check("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulsed mid-RUN must be ignored.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    lat = 0;
    for (int i = 5; i <= 16; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        lat = i;
        chk("mid_sum", 64'(sum), 64'h46);
        chk("mid_cout", 64'(cout), 64'd0);
      end
    end
    chk("mid_dones", 64'(dones), 64'd1);
    chk("mid_lat", 64'(lat), 64'd8);

    // Start held through DONE: back-to-back without IDLE.
    @(negedge clk);
    a = 8'h21; b = 8'h13; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h50; b = 8'h30; sub = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b1_lat", 64'(n), 64'd8);
    chk("b2b1_sum", 64'(sum), 64'h34);
    chk("b2b1_cout", 64'(cout), 64'd0);
    n = 0;
    @(posedge clk); #1;
    n++;
    chk("b2b_busy", 64'(busy), 64'd1);
    start = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b2_gap", 64'(n), 64'd9);
    chk("b2b2_sum", 64'(sum), 64'h20);
    chk("b2b2_cout", 64'(cout), 64'd1);
    chk("b2b2_ovf", 64'(overflow), 64'd0);

    // Async reset in the 4th RUN cycle.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_sum", 64'(sum), 64'h00);
    chk("arst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("arst_nodone", 64'(dones), 64'd0);
    chk("arst_idle_sum", 64'(sum), 64'h00);

    op_check("post_rst", 8'h3C, 8'h0A, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
